// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// uart_tx_fifo : FIFO-buffered UART transmitter, start/data/[parity]/stop.
// Optional parity bit and iPARITY_ODD port: define UART_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                     iCLK_50,
  input  logic                     iRST,
  input  logic [DATA_W-1:0]        iDATA,
  input  logic                     iVALID,
`ifdef UART_TX_PARITY_EN
  input  logic                     iPARITY_ODD,
`endif
  output logic                     oREADY,
  output logic [$clog2(DEPTH):0]   oCOUNT,
  output logic                     oOVF,
  output logic                     oBUSY,
  output logic                     oUART_TXD
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CNT_W    = AW + 1;
  localparam int BIT_W    = $clog2(DATA_W);
  localparam int BAUD_MAX = STOP_BITS * CLKS_PER_BIT;
  localparam int BAUD_W   = $clog2(BAUD_MAX);

  localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [BAUD_W-1:0] C_BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] C_STOP_END = BAUD_W'(BAUD_MAX - 1);
  localparam logic [BIT_W-1:0]  C_LAST_BIT = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic [2:0]        state_q,  state_d;
  logic [BAUD_W-1:0] baud_q,   baud_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              txd_q,    txd_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q,    par_d;
`endif

  logic w_ready;
  logic w_push;
  logic w_pop;

  // Ready comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_ready = (count_q < C_DEPTH);
  assign w_push  = iVALID && w_ready && !iRST;
  assign w_pop   = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (iVALID && !w_ready) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (w_pop) begin
          shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = (^mem_q[rd_ptr_q]) ^ iPARITY_ODD;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == C_BIT_END) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == C_BIT_END) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == C_BIT_END) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_q == C_STOP_END) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // The line is registered from next-state so it changes exactly with state.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (w_push) mem_q[wr_ptr_q] <= iDATA;
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign oREADY    = w_ready;
  assign oCOUNT    = count_q;
  assign oOVF      = ovf_q;
  assign oBUSY     = (state_q != S_IDLE);
  assign oUART_TXD = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_uart_tx_fifo : scoreboard bench, serial line decoded cycle by cycle.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_fifo;

  localparam int C   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P   = 1;
`else
  localparam int P   = 0;
`endif
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       par_odd = 1'b0;
  logic       ready1, ovf1, busy1, txd1;
  logic       ready2, ovf2, busy2, txd2;
  logic [2:0] count1, count2;

  int cyc = 0;
  int n_checks = 0;
  int n_errs = 0;
  logic [7:0] sb [$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut (
    .iCLK_50(clk), .iRST(rst), .iDATA(data1), .iVALID(valid1),
`ifdef UART_TX_PARITY_EN
    .iPARITY_ODD(par_odd),
`endif
    .oREADY(ready1), .oCOUNT(count1), .oOVF(ovf1), .oBUSY(busy1), .oUART_TXD(txd1)
  );

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
    .iCLK_50(clk), .iRST(rst), .iDATA(data2), .iVALID(valid2),
`ifdef UART_TX_PARITY_EN
    .iPARITY_ODD(par_odd),
`endif
    .oREADY(ready2), .oCOUNT(count2), .oOVF(ovf2), .oBUSY(busy2), .oUART_TXD(txd2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic txd_of(input bit sel);
    return sel ? txd2 : txd1;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy2 : busy1;
  endfunction

  function automatic logic [2:0] count_of(input bit sel);
    return sel ? count2 : count1;
  endfunction

  task automatic drive(input bit sel, input logic [7:0] d, input bit acc);
    @(negedge clk);
    check(sel ? "ready2" : "ready", 64'(sel ? ready2 : ready1), 64'(acc));
    if (sel) begin data2 = d; valid2 = 1'b1; end
    else     begin data1 = d; valid1 = 1'b1; end
    if (acc) sb.push_back(d);
  endtask

  task automatic drive_idle;
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  // Waits for a start bit, captures one frame per cycle and compares it with
  // the frame built from the next scoreboard entry.
  task automatic recv_frame(input bit sel, input int stop_b, output int t_start,
                            output int cnt0, output logic [63:0] line);
    int         n, total, busy_cnt, k;
    logic [63:0] expv;
    logic [7:0] d, got_d;
    logic       b;
    total = (1 + 8 + P + stop_b) * C;
    n = 0;
    line = '0;
    t_start = 0;
    cnt0 = 0;
    while (txd_of(sel) !== 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 64'(txd_of(sel)), 64'd0);
    if (txd_of(sel) !== 1'b0) return;
    t_start = cyc;
    cnt0 = int'(count_of(sel));
    busy_cnt = 0;
    for (int o = 0; o < total; o++) begin
      line[o] = txd_of(sel);
      busy_cnt += int'(busy_of(sel));
      @(negedge clk);
    end
    check("busy_idle", 64'(busy_of(sel)), 64'd0);
    check("busy_cycles", 64'(busy_cnt), 64'(total));
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    d = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    expv = '0;
    for (int o = 0; o < total; o++) begin
      k = o / C;
      if (k == 0)                b = 1'b0;
      else if (k <= 8)           b = d[k-1];
      else if (P == 1 && k == 9) b = (^d) ^ par_odd;
      else                       b = 1'b1;
      expv[o] = b;
    end
    for (int j = 0; j < 8; j++) got_d[j] = line[(1 + j) * C + C / 2];
    check("frame_line", line, expv);
    check("data", 64'(got_d), 64'(d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    int t1, t2, t3, c1, c2, c3, n, ta, ca, tb, cb;
    logic [63:0] ln, lnb, lnx;
    bit seen;
    rst = 1'b1; valid1 = 1'b0; valid2 = 1'b0; data1 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_txd",   64'(txd1),   64'd1);
    check("rst_busy",  64'(busy1),  64'd0);
    check("rst_count", 64'(count1), 64'd0);
    check("rst_ready", 64'(ready1), 64'd1);
    check("rst_ovf",   64'(ovf1),   64'd0);
    check("rst_txd2",  64'(txd2),   64'd1);
    rst = 1'b0;

    // Single 0xA5 frame.
    drive(0, 8'hA5, 1'b1);
    drive_idle;
    recv_frame(0, 1, t1, c1, ln);
    check("a5_cnt_at_start", 64'(c1), 64'd0);

    // Three back-to-back frames; the first pop overlaps the second push.
    fork
      begin
        drive(0, 8'h01, 1'b1);
        drive(0, 8'h02, 1'b1);
        drive(0, 8'h03, 1'b1);
        drive_idle;
      end
      begin
        recv_frame(0, 1, t1, c1, ln);
        check("cnt_after_f1", 64'(count1), 64'd2);
        recv_frame(0, 1, t2, c2, ln);
        recv_frame(0, 1, t3, c3, ln);
      end
    join
    check("cnt_f1", 64'(c1), 64'd1);
    check("cnt_f2", 64'(c2), 64'd1);
    check("cnt_f3", 64'(c3), 64'd0);
    check("spacing_12", 64'(t2 - t1), 64'((1 + 8 + P + 1) * C + 1));
    check("spacing_23", 64'(t3 - t2), 64'((1 + 8 + P + 1) * C + 1));

    // Fill while the line is busy, then push into a full FIFO.
    fork
      begin
        drive(0, 8'h11, 1'b1);
        drive_idle;
        repeat (6) @(negedge clk);
        drive(0, 8'h22, 1'b1);
        drive(0, 8'h33, 1'b1);
        drive(0, 8'h44, 1'b1);
        drive(0, 8'h66, 1'b1);
        drive(0, 8'h55, 1'b0);
        drive_idle;
        check("ovf_set",    64'(ovf1),   64'd1);
        check("count_full", 64'(count1), 64'd4);
        check("ready_full", 64'(ready1), 64'd0);
      end
      begin
        for (int i = 0; i < 5; i++) recv_frame(0, 1, ta, ca, lnx);
      end
    join
    check("count_drained", 64'(count1), 64'd0);
    check("sb_empty",      64'(sb.size()), 64'd0);
    check("ovf_sticky",    64'(ovf1), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ovf_cleared", 64'(ovf1), 64'd0);
    rst = 1'b0;

    // Reset during a frame with data still queued; iVALID during reset is ignored.
    drive(0, 8'h3C, 1'b1);
    drive(0, 8'h5A, 1'b1);
    drive_idle;
    n = 0;
    while (txd1 !== 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("abort_start", 64'(txd1), 64'd0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy1), 64'd1);
    rst = 1'b1; valid1 = 1'b1; data1 = 8'hEE;
    @(negedge clk);
    check("abort_txd",   64'(txd1),   64'd1);
    check("abort_busy",  64'(busy1),  64'd0);
    check("abort_count", 64'(count1), 64'd0);
    check("abort_ready", 64'(ready1), 64'd1);
    rst = 1'b0; valid1 = 1'b0;
    sb.delete();
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0) seen = 1'b1;
    end
    check("no_frame_after_rst", 64'(seen), 64'd0);
    check("count_after_rst",    64'(count1), 64'd0);

`ifdef UART_TX_PARITY_EN
    par_odd = 1'b0;
    drive(0, 8'h07, 1'b1);
    drive_idle;
    recv_frame(0, 1, ta, ca, ln);
    check("parity_even", 64'(ln[9 * C + C / 2]), 64'd1);
    par_odd = 1'b1;
    drive(0, 8'h07, 1'b1);
    drive_idle;
    recv_frame(0, 1, ta, ca, ln);
    check("parity_odd", 64'(ln[9 * C + C / 2]), 64'd0);
    par_odd = 1'b0;
`endif

    // Two stop bits on the second instance.
    drive(1, 8'hFF, 1'b1);
    drive(1, 8'hFF, 1'b1);
    drive_idle;
    recv_frame(1, 2, ta, ca, ln);
    recv_frame(1, 2, tb, cb, lnb);
    check("stop2_high", 64'(ln[(9 + P) * C +: 8]), 64'hFF);
    check("stop2_spacing", 64'(tb - ta), 64'((1 + 8 + P + 2) * C + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
